// File: rtl/cardinal_nic_if.sv
// Processor load/store port and ring-router flit port of the cardinal NIC.
// The slave modport is the NIC side; master is the processor/router side.
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64
);
  logic [0:1]            addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal NIC: four memory-mapped registers over one-flit in/out buffers.
// Define CARDINAL_NIC_PKT_CNT_EN to add rx/tx packet counters to the status words.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  cardinal_nic_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_IN_BUF   = 2'b00,
    REG_IN_STAT  = 2'b01,
    REG_OUT_BUF  = 2'b10,
    REG_OUT_STAT = 2'b11
  } reg_sel_e;

  logic [0:DATA_WIDTH-1] in_buf;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  in_full;
  logic                  out_full;

  reg_sel_e              sel;
  logic                  rd_en;
  logic                  wr_en;
  logic                  capture;
  logic                  send;
  logic                  rd_clear;
  logic                  wr_load;
  logic [0:DATA_WIDTH-1] in_stat;
  logic [0:DATA_WIDTH-1] out_stat;
  logic [0:DATA_WIDTH-1] d_out_c;

  assign sel   = reg_sel_e'(bus.addr);
  assign rd_en = bus.nicEn & ~bus.nicWrEn;
  assign wr_en = bus.nicEn &  bus.nicWrEn;

  // Both handshakes are held low during reset even if state is still stale.
  assign bus.net_ri = ~in_full & ~reset;
  assign capture    = bus.net_si & bus.net_ri;
  assign send       = out_full & bus.net_ro & (out_buf[0] == bus.net_polarity) & ~reset;
  assign bus.net_so = send;
  assign bus.net_do = out_buf;

  assign rd_clear = rd_en & (sel == REG_IN_BUF) & in_full;
  assign wr_load  = wr_en & (sel == REG_OUT_BUF) & ~out_full;

  always_ff @(posedge clk) begin
    // NOTE: the flit buffers are ordinary registers, not RAM, so they take the
    // synchronous reset too; a reset must discard any buffered flit.
    if (reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (capture) begin
        in_buf  <= bus.net_di;
        in_full <= 1'b1;
      end else if (rd_clear) begin
        in_full <= 1'b0;
      end

      // A store that lands in the same cycle as a send sees out_full=1 and drops.
      if (send) begin
        out_full <= 1'b0;
      end else if (wr_load) begin
        out_buf  <= bus.d_in;
        out_full <= 1'b1;
      end
    end
  end

`ifdef CARDINAL_NIC_PKT_CNT_EN
  logic [15:0] rx_cnt;
  logic [15:0] tx_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (capture) rx_cnt <= rx_cnt + 16'd1;
      if (send)    tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign in_stat  = {rx_cnt, {(DATA_WIDTH-17){1'b0}}, in_full};
  assign out_stat = {tx_cnt, {(DATA_WIDTH-17){1'b0}}, out_full};
`else
  assign in_stat  = {{(DATA_WIDTH-1){1'b0}}, in_full};
  assign out_stat = {{(DATA_WIDTH-1){1'b0}}, out_full};
`endif

  // Loads are combinational: the processor captures d_out in the same cycle.
  always_comb begin
    d_out_c = '0;
    if (rd_en && !reset) begin
      unique case (sel)
        REG_IN_BUF:   d_out_c = in_buf;
        REG_IN_STAT:  d_out_c = in_stat;
        REG_OUT_BUF:  d_out_c = '0;
        REG_OUT_STAT: d_out_c = out_stat;
      endcase
    end
  end

  assign bus.d_out = d_out_c;

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller at the processor end of the NIC port (`nicEn`, `nicWrEn`, `nic_addr`, `d_out`, `nic_data`) of the cardinal processor. It exposes four memory-mapped 64-bit registers to the processor's load/store path and converts stores and loads into single-flit handshakes with the attached ring router. Each direction has one packet buffer and one status flag.

## Interface
- `DATA_WIDTH`, default 64: flit and register width.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `addr`, input, [0:1]: register select, driven from processor `nic_addr`.
- `d_in`, input, [0:DATA_WIDTH-1]: store data, driven from processor `d_out`.
- `d_out`, output, [0:DATA_WIDTH-1]: load data to processor `nic_data`.
- `nicEn`, input, 1: access enable.
- `nicWrEn`, input, 1: 1 means write, 0 means read. Only meaningful when `nicEn` is 1.
- `net_si`, input, 1: router presents a flit on `net_di`.
- `net_ri`, output, 1: NIC can accept an incoming flit.
- `net_di`, input, [0:DATA_WIDTH-1]: incoming flit.
- `net_so`, output, 1: NIC presents a flit on `net_do`.
- `net_ro`, input, 1: router can accept an outgoing flit.
- `net_do`, output, [0:DATA_WIDTH-1]: outgoing flit.
- `net_polarity`, input, 1: router virtual-channel phase.

## Operation
- State:
  - `in_buf`, `in_full` (input channel).
  - `out_buf`, `out_full` (output channel).
- Register map:
  - 00: input buffer, read.
  - 01: input status, read; returns `{63'b0, in_full}`.
  - 10: output buffer, write.
  - 11: output status, read; returns `{63'b0, out_full}`.
- Read (`nicEn=1`, `nicWrEn=0`):
  - `d_out` is combinational from `addr` in the same cycle, because the processor captures it in EXM.
  - `d_out` is 0 when `nicEn=0` or `nicWrEn=1`.
- A read of 00 with `in_full=1` clears `in_full` at the next edge. A read of 00 with `in_full=0` returns stale `in_buf` and changes no state.
- Write (`nicEn=1`, `nicWrEn=1`):
  - To 10 with `out_full=0`: `out_buf` is loaded with `d_in` and `out_full` is set to 1 at the next edge.
  - To 10 with `out_full=1`: the write is dropped and no state changes. Software must poll 11 first.
  - To 00, 01 or 11: ignored.
- Read with `nicWrEn=0` to address 10: returns 0.
- Input channel:
  - `net_ri = ~in_full`.
  - When `net_si & net_ri`, `in_buf` captures `net_di` and `in_full` is set to 1 at the edge.
  - `net_si` while `net_ri=0` is ignored.
- Output channel:
  - `net_do = out_buf` at all times.
  - `net_so = out_full & net_ro & (out_buf[0] == net_polarity)`. Bit 0 of the flit is the VC bit.
  - At an edge where `net_so=1`, `out_full` clears.
- Simultaneous events:
  - A write to 10 in the same cycle as a send is dropped, because `out_full` is still 1.
  - A read-clear of 00 and an input capture cannot coincide, because `net_ri=0` while full.

## Timing
- Reset values:
  - `in_full=0`, `out_full=0`, `in_buf=0`, `out_buf=0`.
  - `d_out=0`, `net_do=0`, `net_so=0`.
- While `reset` is high, `net_ri` and `net_so` are forced to 0 regardless of state.
- Reset asserted mid-operation discards any buffered flit on both channels.
- Load latency: 0 cycles, combinational. Status updates are visible on the cycle after the causing edge.
- Input channel: one flit accepted per cycle at most. Back-to-back flits require an intervening read of 00.
- Store-to-network latency is at least 1 cycle: the write edge sets `out_full`, and `net_so` can assert in the following cycle if `net_ro` is 1 and polarity matches.
- No combinational path from `net_di` or `net_si` to `net_ri`.

## Configuration
- `CARDINAL_NIC_PKT_CNT_EN` defined:
  - Adds 16-bit counters `rx_cnt` and `tx_cnt`, reset to 0.
  - `rx_cnt` increments on each input capture; `tx_cnt` increments on each `net_so` edge.
  - Both wrap 0xFFFF -> 0x0000.
  - Address 01 reads `{rx_cnt, 47'b0, in_full}`; address 11 reads `{tx_cnt, 47'b0, out_full}`.
- `CARDINAL_NIC_PKT_CNT_EN` undefined: no counters, and status bits 0:62 read 0.

## Test plan
- After reset, read 01 and 11 -> `d_out=0`, `net_ri=1`, `net_so=0`.
- `net_si=1` with `net_di=64'hA5A5_0000_0000_0001`, then next cycle read 01 -> 1 and `net_ri=0`. Read 00 -> same value. Next cycle 01 -> 0 and `net_ri=1`.
- Write 10 with `64'h8000_0000_0000_00FF`, `net_ro=1`, `net_polarity=0` for 3 cycles -> `net_so=0`. Set `net_polarity=1` -> `net_so=1` for exactly one cycle, then 11 reads 0.
- Write 10 with X, hold `net_ro=0`, write 10 with Y -> `net_do` stays X. After release, exactly one send of X.
- Assert `reset` while both buffers are full -> next cycle `net_so=0`, `net_ri=0` during reset, and both statuses read 0 after.
- With `CARDINAL_NIC_PKT_CNT_EN`: preload `rx_cnt=0xFFFF` via 65535 receive/read pairs, then receive once -> 01 reads `{16'h0000, 47'b0, 1'b1}`.
